alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter: MUL_CYCLES, default WIDTH, iterations of the shift-add multiplier.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  request valid.
REQ-006 Port: in_ready  output  1  unit can accept a request.
REQ-007 Port: op  input  4  operation code from ALU control (ALUOp/funct decode).
REQ-008 Port: a, b  input  WIDTH each  operands.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: zero  output  1  result == 0.
REQ-013 Port: ovf  output  1  signed overflow (ADD/SUB only, else 0).
REQ-014 Port: err  output  1  op illegal or disabled.

Function
REQ-015 Op encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1000 MUL (low WIDTH bits, unsigned).
REQ-016 States SHALL be IDLE, BUSY, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a request is accepted on an edge where in_valid && in_ready.
REQ-018 Non-MUL accepted in IDLE: result/zero/ovf/err registered on that edge, state -> DONE; out_valid SHALL be 1 the next cycle (latency 1).
REQ-019 MUL accepted: operands latched, accumulator cleared, counter = 0, state -> BUSY; one shift-add step per cycle; after MUL_CYCLES steps state -> DONE; out_valid asserts MUL_CYCLES+1 cycles after acceptance.
REQ-020 In BUSY, in_valid SHALL be ignored and op/a/b changes SHALL not affect the result.
REQ-021 In DONE, out_valid = 1 and result/zero/ovf/err SHALL hold stable until out_ready = 1; on that edge state -> IDLE.
REQ-022 out_ready while out_valid = 0 SHALL have no effect.
REQ-023 Illegal op: result = 0, zero = 1, ovf = 0, err = 1, latency 1.
REQ-024 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf set on signed overflow.
REQ-025 SLT SHALL use the true signed comparison (independent of SUB overflow).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, zero 0, ovf 0, err 0, counter 0, in_ready 1 after release.
REQ-027 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation; no result is produced after release.

Configuration
REQ-028 Macro ALU_EXEC_MUL_EN defined: MUL supported per REQ-019.
REQ-029 Macro ALU_EXEC_MUL_EN undefined: no multiplier/counter logic; op 1000 treated as illegal per REQ-023; BUSY unreachable.

Structure
REQ-030 Shared package alu_pkg SHALL hold op code constants, state encoding, default WIDTH.
REQ-031 Sub-module alu_mul_seq (shift-add multiplier: start, done, product) SHALL be instantiated only under ALU_EXEC_MUL_EN.

Verification
REQ-032 ADD a=0x7FFFFFFF b=1 -> one cycle later out_valid, result 0x80000000, ovf 1, zero 0.
REQ-033 SUB a=5 b=5 -> result 0, zero 1, ovf 0; SLT a=0xFFFFFFFF b=1 -> result 1.
REQ-034 MUL a=1234 b=5678 (MUL_EN) -> in_ready 0 for 33 cycles, out_valid at cycle 33, result 7006652; without MUL_EN -> err 1, result 0, latency 1.
REQ-035 op 0011 -> err 1, result 0, zero 1.
REQ-036 Backpressure: out_ready held 0 for 10 cycles after AND 0xF0F0 & 0x0FF0 -> result 0x00F0 stable, in_ready 0; out_ready 1 -> IDLE, in_ready 1 next cycle.
REQ-037 rst_n pulsed low at MUL cycle 10 -> outputs 0 immediately, no out_valid after release, next ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: op codes, FSM state
// encoding, default datapath width and the signed-overflow helper.
package alu_pkg;

    localparam int unsigned ALU_DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // Two's-complement add overflow: operands agree in sign, result does not.
    // For subtraction pass the inverted sign of the subtrahend.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial-product step per cycle,
// product (low WIDTH bits, unsigned) valid while done_o is high.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = ALU_DEFAULT_WIDTH,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CW = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES);

    logic             busy_q,   busy_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;

    // Next-state: load on start, otherwise one shift-add step until the count is exhausted.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshake. Single-cycle logic/arith ops;
// optional sequential multiplier enabled by defining ALU_EXEC_MUL_EN (without
// it, op 1000 is reported as illegal and the BUSY state is never entered).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = ALU_DEFAULT_WIDTH,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    alu_state_e       state_q,  state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
    logic             err_q,    err_d;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;
    logic             alu_err_s;
    logic             is_mul_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_prod_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;

`ifdef ALU_EXEC_MUL_EN
    assign is_mul_s = (op == OP_MUL);

    alu_mul_seq #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (in_valid && (state_q == ST_IDLE) && is_mul_s),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );
`else
    assign is_mul_s   = 1'b0;
    assign mul_done_s = 1'b0;
    assign mul_prod_s = '0;
`endif

    // Single-cycle result decode; anything not listed (including MUL here) is illegal.
    always_comb begin
        alu_res_s = '0;
        alu_ovf_s = 1'b0;
        alu_err_s = 1'b0;
        case (op)
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = add_ovf(a[WIDTH-1], ~b[WIDTH-1], diff_s[WIDTH-1]);
            end
            OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: alu_res_s = ~(a | b);
            default: begin
                alu_res_s = '0;
                alu_err_s = 1'b1;
            end
        endcase
    end

    // FSM next-state and result capture: IDLE accepts, BUSY waits for the multiplier, DONE holds until consumed.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_s) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res_s;
                        zero_d   = (alu_res_s == '0);
                        ovf_d    = alu_ovf_s;
                        err_d    = alu_err_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done_s) begin
                    state_d  = ST_DONE;
                    result_d = mul_prod_s;
                    zero_d   = (mul_prod_s == '0);
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule
